// File: rtl/mat_row_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// mat_row_rd_arbiter_if
//
// Bundles every signal between the row arbiter, the row-streaming engines and
// the shared single-ported row RAM.
//
//   Engine side   : req_addr_i / req_valid_i / req_ready_o (one lane per reader)
//                   wr_row_i / wr_addr_i / wr_valid_i / wr_ready_o (write-back)
//                   rsp_row_o / rsp_addr_o / rsp_valid_o (tagged read return)
//   RAM side      : mem_en_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_rdata_i
//   Status        : conflict_cnt_o, busy_o
//
// Modports
//   slave  : the arbiter's view (consumes requests, drives RAM commands)
//   master : the environment's view (engines plus RAM model)
// -----------------------------------------------------------------------------
interface mat_row_rd_arbiter_if #(
    parameter int SIZE    = 16,
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 2
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 2 * WIDTH;

    logic [NUM_REQ-1:0][AW-1:0] req_addr_i;
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic [RW-1:0]              wr_row_i;
    logic [AW-1:0]              wr_addr_i;
    logic                       wr_valid_i;
    logic                       wr_ready_o;
    logic                       mem_en_o;
    logic                       mem_we_o;
    logic [AW-1:0]              mem_addr_o;
    logic [RW-1:0]              mem_wdata_o;
    logic [RW-1:0]              mem_rdata_i;
    logic [RW-1:0]              rsp_row_o;
    logic [AW-1:0]              rsp_addr_o;
    logic [NUM_REQ-1:0]         rsp_valid_o;
    logic [15:0]                conflict_cnt_o;
    logic                       busy_o;

    modport slave (
        input  req_addr_i, req_valid_i, wr_row_i, wr_addr_i, wr_valid_i, mem_rdata_i,
        output req_ready_o, wr_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output rsp_row_o, rsp_addr_o, rsp_valid_o, conflict_cnt_o, busy_o
    );

    modport master (
        output req_addr_i, req_valid_i, wr_row_i, wr_addr_i, wr_valid_i, mem_rdata_i,
        input  req_ready_o, wr_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  rsp_row_o, rsp_addr_o, rsp_valid_o, conflict_cnt_o, busy_o
    );
endinterface

// File: rtl/mat_row_rd_arbiter.sv
// -----------------------------------------------------------------------------
// mat_row_rd_arbiter
//
// Shares one single-ported synchronous row RAM between NUM_REQ row readers and
// one write-back port. At most one RAM access per cycle; the writer always
// wins, readers are served round-robin (or fixed priority, see below). Each
// read row comes back one cycle later, tagged with its address and a one-hot
// owner mask.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   flush_i  : synchronous flush; blocks grants, drops the in-flight response
//              and restarts the round-robin pointer at requester 0
//   bus      : mat_row_rd_arbiter_if.slave (requests, write-back, RAM, response)
//
// Build option
//   MAT_ARB_RR_EN defined   : round-robin among readers
//   MAT_ARB_RR_EN undefined : fixed priority, lowest index wins (no pointer)
// -----------------------------------------------------------------------------
module mat_row_rd_arbiter #(
    parameter int SIZE    = 16,
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    mat_row_rd_arbiter_if.slave  bus
);
    localparam int AW = $clog2(SIZE);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               w_gate;       // grants allowed this cycle
    logic               w_wr_grant;
    logic               w_rd_grant;
    logic [PW-1:0]      w_ptr;        // scan start position
    logic [PW-1:0]      w_win;        // read winner index
    logic [NUM_REQ-1:0] w_ready;
    logic               w_conflict;

    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [AW-1:0]      r_rsp_addr;
    logic [15:0]        r_cnt;

    // Outputs must read as idle while reset is held, so the async reset also
    // gates the combinational grant path.
    assign w_gate     = rst_ni & ~flush_i;
    assign w_wr_grant = w_gate & bus.wr_valid_i;

    // First valid requester found scanning upward from w_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        w_rd_grant = 1'b0;
        w_win      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_rd_grant && bus.req_valid_i[(int'(w_ptr) + k) % NUM_REQ]) begin
                w_rd_grant = 1'b1;
                w_win      = PW'((int'(w_ptr) + k) % NUM_REQ);
            end
        end
        if (!w_gate || bus.wr_valid_i) begin
            w_rd_grant = 1'b0;
        end
    end

    assign w_ready    = w_rd_grant ? (NUM_REQ'(1) << w_win) : '0;
    assign w_conflict = |(bus.req_valid_i & ~w_ready);

    assign bus.req_ready_o = w_ready;
    assign bus.wr_ready_o  = w_wr_grant;
    assign bus.mem_en_o    = w_wr_grant | w_rd_grant;
    assign bus.mem_we_o    = w_wr_grant;
    assign bus.mem_addr_o  = w_wr_grant ? bus.wr_addr_i :
                             (w_rd_grant ? bus.req_addr_i[w_win] : '0);
    assign bus.mem_wdata_o = w_wr_grant ? bus.wr_row_i : '0;

`ifdef MAT_ARB_RR_EN
    logic [PW-1:0] r_ptr;

    // Pointer moves just past the last read winner; writes leave it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of process ordering.
            r_ptr <= '0;
        end else if (flush_i) begin
            r_ptr <= '0;
        end else if (w_rd_grant) begin
            r_ptr <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Response tag: the row itself is the RAM's registered output, so only
    // the owner mask and the address need to be carried one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= '0;
            r_rsp_addr  <= '0;
        end else if (flush_i) begin
            r_rsp_valid <= '0;
            r_rsp_addr  <= '0;
        end else if (w_rd_grant) begin
            r_rsp_valid <= w_ready;
            r_rsp_addr  <= bus.req_addr_i[w_win];
        end else begin
            r_rsp_valid <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_conflict && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // A flush in the cycle a response is presented must also hide it, so the
    // owner mask is masked combinationally as well as cleared at the edge.
    assign bus.rsp_valid_o    = r_rsp_valid & {NUM_REQ{~flush_i}};
    assign bus.rsp_addr_o     = r_rsp_addr;
    assign bus.rsp_row_o      = bus.mem_rdata_i;
    assign bus.busy_o         = |bus.rsp_valid_o;
    assign bus.conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_mat_row_rd_arbiter.sv
module tb_mat_row_rd_arbiter;
    localparam int SIZE    = 16;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 2;
    localparam int AW      = $clog2(SIZE);
    localparam int RW      = SIZE * 2 * WIDTH;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic flush_i;

    mat_row_rd_arbiter_if #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    mat_row_rd_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Environment: single-ported synchronous RAM, read data one cycle later.
    logic [RW-1:0] ram [SIZE];
    always @(posedge clk_i) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              bus.mem_rdata_i     <= ram[bus.mem_addr_o];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int                 m_ptr;
    logic [NUM_REQ-1:0] m_rsp_valid;
    logic [AW-1:0]      m_rsp_addr;
    logic [RW-1:0]      m_rsp_row;
    int                 m_cnt;
    logic [RW-1:0]      m_mem [SIZE];
    logic [NUM_REQ-1:0] last_ready;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr       = 0;
        m_rsp_valid = '0;
        m_rsp_addr  = '0;
        m_cnt       = 0;
        last_ready  = '0;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.wr_valid_i  = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_row_i    = '0;
        flush_i         = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle,
    // advances the model, and returns at the next falling edge.
    task automatic step(input bit chk);
        int                 win;
        bit                 wr_g;
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] vld;
        logic [AW-1:0]      exp_addr;
        logic [NUM_REQ-1:0] exp_rsp;
        #1;
        win       = -1;
        exp_ready = '0;
        vld       = bus.req_valid_i;
        wr_g      = bus.wr_valid_i && !flush_i;
        if (!flush_i && !bus.wr_valid_i) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (win < 0 && vld[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_addr = '0;
        if (wr_g)          exp_addr = bus.wr_addr_i;
        else if (win >= 0) exp_addr = bus.req_addr_i[win];
        exp_rsp = flush_i ? '0 : m_rsp_valid;
        if (chk) begin
            check("wr_ready", RW'(bus.wr_ready_o), RW'(wr_g));
            check("req_ready", RW'(bus.req_ready_o), RW'(exp_ready));
            check("mem_en", RW'(bus.mem_en_o), RW'(wr_g || win >= 0));
            check("mem_we", RW'(bus.mem_we_o), RW'(wr_g));
            if (wr_g || win >= 0) check("mem_addr", RW'(bus.mem_addr_o), RW'(exp_addr));
            if (wr_g) check("mem_wdata", bus.mem_wdata_o, bus.wr_row_i);
            check("rsp_valid", RW'(bus.rsp_valid_o), RW'(exp_rsp));
            check("busy", RW'(bus.busy_o), RW'(|exp_rsp));
            if (|exp_rsp) begin
                check("rsp_addr", RW'(bus.rsp_addr_o), RW'(m_rsp_addr));
                check("rsp_row", bus.rsp_row_o, m_rsp_row);
            end
            check("conflict_cnt", RW'(bus.conflict_cnt_o), RW'(m_cnt));
        end
        last_ready = exp_ready;
        if (|(vld & ~exp_ready) && m_cnt < 65535) m_cnt++;
        if (wr_g) m_mem[bus.wr_addr_i] = bus.wr_row_i;
        if (flush_i) begin
            m_rsp_valid = '0;
            m_rsp_addr  = '0;
            m_ptr       = 0;
        end else if (win >= 0) begin
            m_rsp_valid = exp_ready;
            m_rsp_addr  = exp_addr;
            m_rsp_row   = m_mem[exp_addr];
`ifdef MAT_ARB_RR_EN
            m_ptr       = (win + 1) % NUM_REQ;
`endif
        end else begin
            m_rsp_valid = '0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Random stimulus honouring the hold-until-granted rule.
    task automatic rand_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!(bus.req_valid_i[i] && !last_ready[i])) begin
                bus.req_valid_i[i] = ($urandom_range(0, 99) < 60);
                bus.req_addr_i[i]  = AW'($urandom_range(0, SIZE - 1));
            end
        end
        bus.wr_valid_i = ($urandom_range(0, 99) < 20);
        bus.wr_addr_i  = AW'($urandom_range(0, SIZE - 1));
        bus.wr_row_i   = rand_row();
        flush_i        = ($urandom_range(0, 99) < 5);
    endtask

    logic [RW-1:0] p3;
    logic [RW-1:0] w5;
    int            cnt0;

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();

        // Reset: requests present but nothing may be granted.
        bus.req_valid_i = '1;
        bus.wr_valid_i  = 1'b1;
        @(negedge clk_i);
        #1;
        check("rst_req_ready", RW'(bus.req_ready_o), RW'(0));
        check("rst_wr_ready", RW'(bus.wr_ready_o), RW'(0));
        check("rst_mem_en", RW'(bus.mem_en_o), RW'(0));
        check("rst_mem_we", RW'(bus.mem_we_o), RW'(0));
        check("rst_rsp_valid", RW'(bus.rsp_valid_o), RW'(0));
        check("rst_rsp_addr", RW'(bus.rsp_addr_o), RW'(0));
        check("rst_busy", RW'(bus.busy_o), RW'(0));
        check("rst_cnt", RW'(bus.conflict_cnt_o), RW'(0));
        @(negedge clk_i);
        clear_inputs();
        rst_ni = 1'b1;

        // Preload every row through the write port.
        for (int a = 0; a < SIZE; a++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_addr_i  = AW'(a);
            bus.wr_row_i   = rand_row();
            if (a == 3) p3 = bus.wr_row_i;
            step(1);
        end
        bus.wr_valid_i = 1'b0;

        // Single read of row 3.
        bus.req_valid_i = 2'b01;
        bus.req_addr_i[0] = AW'(3);
        #1;
        check("t1_ready_same_cycle", RW'(bus.req_ready_o), RW'(2'b01));
        step(1);
        bus.req_valid_i = '0;
        #1;
        check("t1_rsp_valid", RW'(bus.rsp_valid_o), RW'(2'b01));
        check("t1_rsp_addr", RW'(bus.rsp_addr_o), RW'(3));
        check("t1_rsp_row", bus.rsp_row_o, p3);
        step(1);

        // Flush to restart the pointer, then both requesters continuously.
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        bus.req_valid_i   = 2'b11;
        bus.req_addr_i[0] = AW'(1);
        bus.req_addr_i[1] = AW'(2);
        cnt0 = m_cnt;
        for (int c = 0; c < 6; c++) begin
            #1;
`ifdef MAT_ARB_RR_EN
            check("t2_alternate", RW'(bus.req_ready_o), RW'((c % 2 == 0) ? 2'b01 : 2'b10));
            if (c > 0) check("t2_rsp_addr_seq", RW'(bus.rsp_addr_o), RW'((c % 2 == 1) ? 1 : 2));
`else
            check("t2_fixed_prio", RW'(bus.req_ready_o), RW'(2'b01));
`endif
            step(1);
        end
        #1;
        check("t2_cnt_plus6", RW'(bus.conflict_cnt_o), RW'(cnt0 + 6));
        bus.req_valid_i = '0;
        step(1);

        // Write to row 5 while both reads wait, then read it back.
        w5 = rand_row();
        bus.req_valid_i   = 2'b11;
        bus.req_addr_i[0] = AW'(5);
        bus.req_addr_i[1] = AW'(5);
        bus.wr_valid_i    = 1'b1;
        bus.wr_addr_i     = AW'(5);
        bus.wr_row_i      = w5;
        step(1);
        bus.wr_valid_i = 1'b0;
        step(1);
        #1;
        check("t3_read_after_write", bus.rsp_row_o, w5);
        step(1);
        bus.req_valid_i = '0;
        step(1);

        // Read granted in N, flush in N+1.
        bus.req_valid_i   = 2'b01;
        bus.req_addr_i[0] = AW'(7);
        step(1);
        bus.req_valid_i = '0;
        flush_i = 1'b1;
        #1;
        check("t4_rsp_n1", RW'(bus.rsp_valid_o), RW'(0));
        step(1);
        flush_i = 1'b0;
        bus.req_valid_i = 2'b11;
        #1;
        check("t4_rsp_n2", RW'(bus.rsp_valid_o), RW'(0));
        check("t4_ptr_zero", RW'(bus.req_ready_o), RW'(2'b01));
        step(1);

        // Saturation: both requesters valid for a long run.
        for (int c = 0; c < 66000; c++) step(0);
        #1;
        check("t5_cnt_sat", RW'(bus.conflict_cnt_o), RW'(16'hFFFF));
        for (int c = 0; c < 3; c++) step(1);
        #1;
        check("t5_cnt_hold", RW'(bus.conflict_cnt_o), RW'(16'hFFFF));
        bus.req_valid_i = '0;
        step(1);

        // Randomized traffic against the model.
        last_ready = '0;
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step(1);
        end

        // Reset while a response is in flight.
        clear_inputs();
        step(1);
        bus.req_valid_i   = 2'b10;
        bus.req_addr_i[1] = AW'(9);
        step(1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_rsp_valid", RW'(bus.rsp_valid_o), RW'(0));
        check("t6_rst_busy", RW'(bus.busy_o), RW'(0));
        check("t6_rst_mem_en", RW'(bus.mem_en_o), RW'(0));
        check("t6_rst_cnt", RW'(bus.conflict_cnt_o), RW'(0));
        @(negedge clk_i);
        clear_inputs();
        rst_ni = 1'b1;
        model_reset();
        step(1);
        step(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mat_row_rd_arbiter.md
# mat_row_rd_arbiter

Shares one single-ported, synchronous matrix row buffer between several row-streaming engines (LU decomposition, triangular inverse, and similar). Grants at most one access per cycle: the writer has priority, and read requesters are served round-robin. Returns each read row, tagged with its address, to the requester that issued it. It sits between the engines' row address and data ports and the shared row RAM in the block-inversion datapath.

## Interface
- SIZE, 16, matrix dimension; rows per buffer; address width AW = $clog2(SIZE)
- WIDTH, 64, bits per real/imag component; row width RW = SIZE*2*WIDTH, element j = {imag, real} at bits [j*2*WIDTH +: 2*WIDTH]
- NUM_REQ, 2, number of read requesters (requester 0 = LU, 1 = triangular inverse)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush: drops in-flight response, resets arbitration state
- req_addr_i  in  NUM_REQ x AW  read row address per requester
- req_valid_i  in  NUM_REQ  read request per requester
- req_ready_o  out  NUM_REQ  grant; request accepted when valid & ready
- wr_row_i  in  RW  write-back row (from LU)
- wr_addr_i  in  AW  write-back address
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted
- mem_en_o  out  1  RAM access enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  AW  RAM address
- mem_wdata_o  out  RW  RAM write data
- mem_rdata_i  in  RW  RAM read data, valid one cycle after read access
- rsp_row_o  out  RW  returned row, broadcast to all requesters
- rsp_addr_o  out  AW  address of returned row
- rsp_valid_o  out  NUM_REQ  one-hot: which requester owns rsp_row_o
- conflict_cnt_o  out  16  saturating count of cycles with an ungranted valid read
- busy_o  out  1  a read response is in flight

## Operation
- Priority each cycle: write, then reads. If wr_valid_i is high, wr_ready_o is 1, all req_ready_o are 0, and mem_en_o = mem_we_o = 1 with mem_addr_o = wr_addr_i and mem_wdata_o = wr_row_i.
- With no write, the read winner is the first requester with valid set, scanning from pointer ptr upward modulo NUM_REQ. The winner gets req_ready_o = 1 and drives mem_en_o = 1, mem_we_o = 0, mem_addr_o = req_addr_i[winner]. Exactly one ready bit is high at most.
- After a read grant to requester i, ptr <= (i+1) mod NUM_REQ. Write grants do not change ptr.
- Response register: on a read grant, the winner's one-hot and address are captured and presented next cycle on rsp_valid_o and rsp_addr_o. rsp_row_o = mem_rdata_i, combinational pass-through.
- conflict_cnt_o increments when any req_valid_i bit is high and no req_valid_i & req_ready_o pair fires in that bit's position. The count holds at 16'hFFFF and clears only on reset.
- busy_o = |rsp_valid_o.
- Requesters hold req_valid_i and req_addr_i stable until granted. The arbiter does not store requests.
- No valid inputs: mem_en_o = 0, ptr holds.

## Timing
- Grant and RAM command are combinational from inputs and registered state, so zero-cycle grant.
- Read latency: grant in cycle N, rsp_valid_o and rsp_row_o in cycle N+1. Back-to-back grants give one response per cycle.
- Write takes effect at RAM in the grant cycle. A read of the same address granted in cycle N+1 returns the new data.
- Reset values: ptr = 0, rsp_valid_o = 0, rsp_addr_o = 0, conflict_cnt_o = 0, busy_o = 0. All ready and mem_* outputs are 0 while rst_ni is low.
- flush_i high: no grants that cycle (all ready = 0, mem_en_o = 0). The response register clears, so rsp_valid_o = 0 next cycle. ptr resets to 0.
- Reset or flush asserted while a response is in flight: that response is discarded and never appears.
- Single-requester case (NUM_REQ = 1): ptr is constant 0; the block behaves as write-priority mux plus response tag.

## Configuration
- MAT_ARB_RR_EN defined: round-robin as specified above.
- MAT_ARB_RR_EN undefined: fixed priority, lowest index wins; ptr register is removed and the scan always starts at 0. Write priority, latency and counter are unchanged.

## Test plan
- Reset, then requester 0 valid with addr 3 and RAM row 3 = pattern P3 -> ready[0] in the same cycle; next cycle rsp_valid_o = 2'b01, rsp_addr_o = 3, rsp_row_o = P3.
- Both requesters valid continuously, addresses 1 and 2, RR enabled -> grants alternate 0, 1, 0, 1; rsp_addr_o sequence 1, 2, 1, 2; conflict_cnt_o increments by 1 per cycle.
- wr_valid_i to addr 5 with data W while both reads valid -> wr_ready_o = 1, both ready = 0, ptr unchanged. Next cycle read of addr 5 returns W.
- Read granted in cycle N, flush_i high in cycle N+1 -> rsp_valid_o = 0 in cycles N+1 and N+2, ptr = 0 afterwards.
- Both requesters valid for 70000 cycles -> conflict_cnt_o saturates at 16'hFFFF and holds there.
- MAT_ARB_RR_EN undefined, both requesters valid -> requester 0 granted every cycle, ready[1] stays 0.
